// File: rtl/reg_scoreboard_if.sv
// Bundle between decode/issue, writeback and the register-busy scoreboard.
// master: issue/writeback/decode side. It drives the requests and source
//         queries and reads back the status.
// slave : the scoreboard.
// Signals:
//   issue_valid/issue_reg/issue_ready  destination ownership handshake
//   wb_valid/wb_reg                    writeback completion
//   read_reg_a/b, busy_a/b             source-operand hazard query
//   busy_vec, wr_onehot, busy_count    registered status and RF write enable
//   err_spurious_wb                    sticky error flag
interface reg_scoreboard_if #(
  parameter int ADDR_W = 5
);
  localparam int NUM_REGS = 2**ADDR_W;

  logic                issue_valid;
  logic [ADDR_W-1:0]   issue_reg;
  logic                issue_ready;
  logic                wb_valid;
  logic [ADDR_W-1:0]   wb_reg;
  logic [ADDR_W-1:0]   read_reg_a;
  logic [ADDR_W-1:0]   read_reg_b;
  logic                busy_a;
  logic                busy_b;
  logic [NUM_REGS-1:0] busy_vec;
  logic [NUM_REGS-1:0] wr_onehot;
  logic [ADDR_W:0]     busy_count;
  logic                err_spurious_wb;

  modport master (
    output issue_valid, issue_reg, wb_valid, wb_reg, read_reg_a, read_reg_b,
    input  issue_ready, busy_a, busy_b, busy_vec, wr_onehot, busy_count,
           err_spurious_wb
  );

  modport slave (
    input  issue_valid, issue_reg, wb_valid, wb_reg, read_reg_a, read_reg_b,
    output issue_ready, busy_a, busy_b, busy_vec, wr_onehot, busy_count,
           err_spurious_wb
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register-busy scoreboard. It tracks the architectural registers that have
// a write in flight: the bit is set on issue and cleared on writeback. It
// stalls dependent issue and produces the registered one-hot write enable
// for the register file.
// Ports:
//   clock       rising-edge clock
//   ctrl_reset  synchronous active-high reset
//   sb          reg_scoreboard_if.slave (see the interface for signal list)
module reg_scoreboard #(
  parameter int ADDR_W         = 5,
  parameter bit ZERO_HARDWIRED = 1'b1
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  reg_scoreboard_if.slave  sb
);
  localparam int NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  logic [NUM_REGS-1:0] busy_q, busy_nxt;
  logic [NUM_REGS-1:0] onehot_q, onehot_nxt;
  logic [ADDR_W:0]     count_q, count_nxt;
  logic                err_q;

  logic clr_hit_issue, clr_hit_a, clr_hit_b;
  logic zero_issue, zero_a, zero_b, zero_wb;
  logic issue_ready;
  logic set_eff, clr_eff;

  assign clr_hit_issue = sb.wb_valid && (sb.wb_reg == sb.issue_reg);
  assign clr_hit_a     = sb.wb_valid && (sb.wb_reg == sb.read_reg_a);
  assign clr_hit_b     = sb.wb_valid && (sb.wb_reg == sb.read_reg_b);

  assign zero_issue = ZERO_HARDWIRED && (sb.issue_reg == '0);
  assign zero_a     = ZERO_HARDWIRED && (sb.read_reg_a == '0);
  assign zero_b     = ZERO_HARDWIRED && (sb.read_reg_b == '0);
  assign zero_wb    = ZERO_HARDWIRED && (sb.wb_reg == '0);

  // Same-cycle writeback frees the register, so issue and decode need not
  // wait for the bitmap to update.
  assign issue_ready = sb.issue_valid &&
                       (!busy_q[sb.issue_reg] || clr_hit_issue || zero_issue);

  assign sb.issue_ready = issue_ready;
  assign sb.busy_a      = busy_q[sb.read_reg_a] && !clr_hit_a && !zero_a;
  assign sb.busy_b      = busy_q[sb.read_reg_b] && !clr_hit_b && !zero_b;
  assign sb.busy_vec    = busy_q;
  assign sb.wr_onehot   = onehot_q;
  assign sb.busy_count  = count_q;
  assign sb.err_spurious_wb = err_q;

  // An accepted issue to a non-hardwired register always yields a set bit
  // after the edge. A writeback lowers the count only if the bit was set.
  // When both hit the same busy register, the net change is zero.
  assign set_eff = issue_ready && !zero_issue;
  assign clr_eff = sb.wb_valid && busy_q[sb.wb_reg];

  always_comb begin
    busy_nxt = busy_q;
    if (sb.wb_valid) busy_nxt[sb.wb_reg] = 1'b0;
    if (issue_ready) busy_nxt[sb.issue_reg] = 1'b1;
    if (ZERO_HARDWIRED) busy_nxt[0] = 1'b0;

    onehot_nxt = '0;
    if (sb.wb_valid) onehot_nxt[sb.wb_reg] = 1'b1;
    if (ZERO_HARDWIRED) onehot_nxt[0] = 1'b0;

    count_nxt = count_q;
    case ({set_eff, clr_eff})
      2'b10:   count_nxt = count_q + CNT_ONE;
      2'b01:   count_nxt = count_q - CNT_ONE;
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      busy_q   <= '0;
      onehot_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      busy_q   <= busy_nxt;
      onehot_q <= onehot_nxt;
      count_q  <= count_nxt;
      if (sb.wb_valid && !busy_q[sb.wb_reg] && !zero_wb) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios followed by random traffic,
// all checked against a set-of-owned-registers model.
module tb_reg_scoreboard;
  localparam int AW = 5;
  localparam int NR = 32;

  logic clock = 1'b0;
  logic ctrl_reset = 1'b1;
  always #5 clock = ~clock;

  reg_scoreboard_if #(.ADDR_W(AW)) sb ();
  reg_scoreboard_if #(.ADDR_W(3))  sb8 ();

  reg_scoreboard #(.ADDR_W(AW), .ZERO_HARDWIRED(1'b1)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .sb(sb));
  reg_scoreboard #(.ADDR_W(3), .ZERO_HARDWIRED(1'b1)) dut8 (
    .clock(clock), .ctrl_reset(ctrl_reset), .sb(sb8));

  int checks = 0;
  int failures = 0;

  // Reference model: the set of registers with a pending write, plus the
  // sticky error flag.
  bit m_busy[NR];
  bit m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit iv, input int ir, input bit wv, input int wr,
                       input int ra, input int rb);
    sb.issue_valid = iv;
    sb.issue_reg   = ir[AW-1:0];
    sb.wb_valid    = wv;
    sb.wb_reg      = wr[AW-1:0];
    sb.read_reg_a  = ra[AW-1:0];
    sb.read_reg_b  = rb[AW-1:0];
  endtask

  // One clock cycle with the inputs already driven. It checks the
  // combinational outputs before the edge and the registered outputs after it.
  task automatic step(input bit rst);
    int ir, wr, ra, rb, cnt;
    bit iv, wv, exp_ready;
    logic [NR-1:0] exp_vec, exp_oh;
    #1;
    iv = sb.issue_valid; wv = sb.wb_valid;
    ir = int'(sb.issue_reg); wr = int'(sb.wb_reg);
    ra = int'(sb.read_reg_a); rb = int'(sb.read_reg_b);
    exp_ready = iv && (!m_busy[ir] || (wv && wr == ir) || ir == 0);
    chk("issue_ready", 64'(sb.issue_ready), 64'(exp_ready));
    chk("busy_a", 64'(sb.busy_a), 64'(m_busy[ra] && !(wv && wr == ra) && ra != 0));
    chk("busy_b", 64'(sb.busy_b), 64'(m_busy[rb] && !(wv && wr == rb) && rb != 0));
    ctrl_reset = rst;
    @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    exp_oh = '0;
    if (rst) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_err = 1'b0;
    end else begin
      if (wv) begin
        if (!m_busy[wr] && wr != 0) m_err = 1'b1;
        m_busy[wr] = 1'b0;
        if (wr != 0) exp_oh[wr] = 1'b1;
      end
      if (exp_ready && ir != 0) m_busy[ir] = 1'b1;
    end
    cnt = 0;
    for (int i = 0; i < NR; i++) begin
      exp_vec[i] = m_busy[i];
      cnt += int'(m_busy[i]);
    end
    chk("busy_vec", 64'(sb.busy_vec), 64'(exp_vec));
    chk("wr_onehot", 64'(sb.wr_onehot), 64'(exp_oh));
    chk("busy_count", 64'(sb.busy_count), 64'(cnt));
    chk("err_spurious_wb", 64'(sb.err_spurious_wb), 64'(m_err));
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    sb8.issue_valid = 0; sb8.issue_reg = '0; sb8.wb_valid = 0; sb8.wb_reg = '0;
    sb8.read_reg_a = '0; sb8.read_reg_b = '0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_err = 1'b0;
    @(posedge clock); #1;
    step(1'b1);

    // 8-register instance: issue 7, then write it back.
    sb8.issue_valid = 1; sb8.issue_reg = 3'd7;
    #1 chk("n8_issue_ready", 64'(sb8.issue_ready), 64'd1);
    @(posedge clock); #1;
    chk("n8_busy_vec", 64'(sb8.busy_vec), 64'h80);
    sb8.issue_valid = 0; sb8.wb_valid = 1; sb8.wb_reg = 3'd7;
    @(posedge clock); #1;
    sb8.wb_valid = 0;
    chk("n8_wr_onehot", 64'(sb8.wr_onehot), 64'h80);
    chk("n8_busy_count", 64'(sb8.busy_count), 64'd0);
    chk("n8_err", 64'(sb8.err_spurious_wb), 64'd0);

    // Issue 5, then query it.
    drive(1, 5, 0, 0, 5, 0); step(0);
    chk("vec_after_issue5", 64'(sb.busy_vec), 64'h20);
    drive(0, 0, 0, 0, 5, 0); step(0);
    chk("cnt_after_issue5", 64'(sb.busy_count), 64'd1);
    // Reissue while busy stalls; then a same-cycle writeback lets it through.
    drive(1, 5, 0, 0, 5, 5); step(0);
    drive(1, 5, 1, 5, 5, 5); step(0);
    chk("wb_issue_same_oh", 64'(sb.wr_onehot), 64'h20);
    chk("wb_issue_same_vec", 64'(sb.busy_vec), 64'h20);
    drive(0, 0, 1, 5, 0, 0); step(0);
    // Register 0 is hardwired.
    drive(1, 0, 0, 0, 0, 0); step(0);
    drive(0, 0, 1, 0, 0, 0); step(0);
    chk("zero_wb_err", 64'(sb.err_spurious_wb), 64'd0);
    // Fill 1..31 and drain.
    for (int r = 1; r < NR; r++) begin drive(1, r, 0, 0, r, r - 1); step(0); end
    chk("full_count", 64'(sb.busy_count), 64'd31);
    chk("full_vec", 64'(sb.busy_vec), 64'hFFFF_FFFE);
    for (int r = 1; r < NR; r++) begin drive(0, 0, 1, r, r, 31); step(0); end
    chk("drain_count", 64'(sb.busy_count), 64'd0);
    // Spurious writeback to 9.
    drive(0, 0, 1, 9, 0, 0); step(0);
    chk("spurious_err", 64'(sb.err_spurious_wb), 64'd1);
    chk("spurious_oh", 64'(sb.wr_onehot), 64'h200);
    drive(0, 0, 0, 0, 0, 0); step(0);
    chk("spurious_sticky", 64'(sb.err_spurious_wb), 64'd1);
    // Reset while busy, with simultaneous issue/writeback.
    drive(1, 3, 0, 0, 0, 0); step(0);
    drive(1, 4, 0, 0, 0, 0); step(0);
    drive(1, 6, 1, 3, 6, 4); step(1);
    chk("reset_vec", 64'(sb.busy_vec), 64'd0);
    chk("reset_err", 64'(sb.err_spurious_wb), 64'd0);

    // Random traffic, with small register ranges to force collisions.
    for (int n = 0; n < 600; n++) begin
      int lim;
      lim = ($urandom_range(0, 3) == 0) ? 31 : 7;
      drive($urandom_range(0, 1), $urandom_range(0, lim),
            $urandom_range(0, 2) == 0, $urandom_range(0, lim),
            $urandom_range(0, lim), $urandom_range(0, lim));
      step($urandom_range(0, 79) == 0);
    end

    drive(0, 0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
